// File: rtl/sipo_128.sv
// ---------------------------------------------------------------------------
// sipo_128 : serial-in / parallel-out byte assembler
//
// Collects NUM_WORDS bytes into one DATA_W*NUM_WORDS bit block. Every level
// change on Wr delivers one byte. It sits between the UART receiver and the
// AES core.
//
// Ports
//   clk           in   1               rising-edge clock
//   reset         in   1               synchronous, active-high
//   Wr            in   1               toggle-write strobe (each 0->1 or 1->0 = one byte)
//   serial_in     in   DATA_W          byte sampled on the edge that sees the toggle
//   parallel_out  out  DATA_W*NUM_WORDS assembled block, registered
//   full          out  1               block complete, registered
//
// Handshake: there is no valid/ready pair. A byte is accepted on every rising
// clk edge where Wr differs from its value one cycle earlier. The sender must
// hold serial_in stable on that edge. There is no back-pressure, so the
// upstream must not toggle faster than once per clock.
// ---------------------------------------------------------------------------
module sipo_128 #(
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Wr,
  input  logic [DATA_W-1:0]           serial_in,
  output logic [DATA_W*NUM_WORDS-1:0] parallel_out,
  output logic                        full
);

  localparam int BLK_W = DATA_W * NUM_WORDS;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  logic             wr_q;
  logic [CNT_W-1:0] count;
  logic             capture;

  // The toggle is detected against the registered strobe, so a byte is
  // captured on the very edge where the new Wr level is first seen.
  assign capture = (Wr != wr_q);

  always_ff @(posedge clk) begin
    // Track Wr even during reset. A level held through reset release then
    // looks "old" and does not fire a capture.
    wr_q <= Wr;
    if (reset) begin
      parallel_out <= '0;
      full         <= 1'b0;
      count        <= '0;
    end else if (capture) begin
      parallel_out <= {parallel_out[BLK_W-DATA_W-1:0], serial_in};
      if (count == LAST) begin
        count <= '0;
        full  <= 1'b1;
      end else begin
        // A capture while full lands here with count==0. It opens a new block
        // and clears full.
        count <= count + 1'b1;
        full  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_128.sv
// ---------------------------------------------------------------------------
// tb_sipo_128 : self-checking bench for sipo_128.
// The reference model keeps the history of bytes captured since reset.
// parallel_out is expected to equal the newest (up to) 16 bytes packed
// oldest-first, with zeros above them. full is expected high exactly when a
// non-zero multiple of 16 bytes has been captured since reset.
// ---------------------------------------------------------------------------
module tb_sipo_128;

  localparam int DATA_W    = 8;
  localparam int NUM_WORDS = 16;
  localparam int BLK_W     = DATA_W * NUM_WORDS;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              Wr;
  logic [DATA_W-1:0] serial_in;
  logic [BLK_W-1:0]  parallel_out;
  logic              full;

  always #5 clk = ~clk;

  sipo_128 #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .Wr           (Wr),
    .serial_in    (serial_in),
    .parallel_out (parallel_out),
    .full         (full)
  );

  // ---------------- scoreboard / model ----------------
  logic [DATA_W-1:0] exp_q[$];  // newest NUM_WORDS bytes captured since reset
  int                n_cap;     // bytes captured since reset
  int                n_checks;
  int                n_pass;

  function automatic logic [BLK_W-1:0] model_po();
    logic [BLK_W-1:0] r;
    r = '0;
    foreach (exp_q[i]) r = {r[BLK_W-DATA_W-1:0], exp_q[i]};
    return r;
  endfunction

  function automatic logic model_full();
    return (n_cap > 0) && (n_cap % NUM_WORDS == 0);
  endfunction

  task automatic check(input string tag, input logic [BLK_W-1:0] got,
                       input logic [BLK_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- driver ----------------
  // One clock: drive inputs, let the edge happen, update the model, then
  // compare just after the edge.
  task automatic cycle(input bit tog, input logic [DATA_W-1:0] b);
    serial_in = b;
    if (tog) Wr = ~Wr;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      n_cap = 0;
    end else if (tog) begin
      exp_q.push_back(b);
      if (exp_q.size() > NUM_WORDS) void'(exp_q.pop_front());
      n_cap++;
    end
    #1;
    check("po", parallel_out, model_po());
    check("full", BLK_W'(full), BLK_W'(model_full()));
  endtask

  task automatic do_reset(input bit tog);
    reset = 1'b1;
    cycle(tog, 8'h55);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, DATA_W'($urandom));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [BLK_W-1:0] snap;
    n_checks  = 0;
    n_pass    = 0;
    n_cap     = 0;
    reset     = 1'b1;
    Wr        = 1'b0;
    serial_in = '0;
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    reset = 1'b0;
    check("reset_po", parallel_out, '0);
    check("reset_full", BLK_W'(full), '0);

    // Tests 1/2: consecutive toggles with bytes 0x00..0x0F.
    for (int i = 0; i < 15; i++) cycle(1'b1, DATA_W'(i));
    check("t2_full15", BLK_W'(full), '0);
    check("t2_po15", parallel_out, 128'h000102030405060708090A0B0C0D0E);
    cycle(1'b1, 8'h0F);
    check("t1_full", BLK_W'(full), BLK_W'(1));
    check("t1_po", parallel_out, 128'h000102030405060708090A0B0C0D0E0F);

    // Test 3: hold after full, then one more byte starts a new block.
    snap = parallel_out;
    idle(20);
    check("t3_hold_po", parallel_out, snap);
    check("t3_hold_full", BLK_W'(full), BLK_W'(1));
    cycle(1'b1, 8'hAA);
    check("t3_new_full", BLK_W'(full), '0);
    check("t3_new_lsb", BLK_W'(parallel_out[7:0]), BLK_W'(8'hAA));

    // Test 4: reset mid-block, then a full block of fresh bytes.
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, DATA_W'($urandom));
    do_reset(1'b0);
    check("t4_rst_po", parallel_out, '0);
    check("t4_rst_full", BLK_W'(full), '0);
    for (int i = 0; i < 16; i++) cycle(1'b1, DATA_W'(8'hC0 + i));
    check("t4_po", parallel_out, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    check("t4_full", BLK_W'(full), BLK_W'(1));

    // Test 5: Wr held high through reset release; a toggle coincident with
    // reset must not be captured.
    Wr = 1'b0;
    do_reset(1'b1);
    idle(10);
    check("t5_po", parallel_out, '0);
    check("t5_full", BLK_W'(full), '0);

    // Test 6: UART-paced toggles, 3-5 clocks apart.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, DATA_W'($urandom));
      idle($urandom_range(2, 4));
    end
    check("t6_full", BLK_W'(full), BLK_W'(1));
    check("t6_cnt", BLK_W'(n_cap), BLK_W'(16));

    // Random soak: random toggles, bytes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 1) == 1);
      else cycle($urandom_range(0, 2) != 0, DATA_W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
